// File: rtl/par_dispatcher_pkg.sv
// par_dispatcher_pkg: shared types for the partition dispatcher.
// Provides the control-phase encodings, the FSM state enum and the partition table entry.
package par_dispatcher_pkg;
    localparam int ADDR_W = 32;
    localparam int SIZE_W = 32;
    typedef enum logic [1:0] {PH_IDLE = 2'd0, PH_SCATTER = 2'd1, PH_GATHER = 2'd2} phase_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
    } entry_t;
endpackage

// File: rtl/par_dispatcher_if.sv
// par_dispatcher_if: bus between the phase controller / PE array and the dispatcher.
// master drives control, cfg_* (table writes), pe_req and pe_done;
// slave drives grant_* (one-cycle grant), pe_busy, phase_done and err.
interface par_dispatcher_if
    import par_dispatcher_pkg::*;
#(
    parameter int PE_NUM    = 16,
    parameter int PAR_NUM_W = 5
);
    logic [1:0]           control;
    logic                 cfg_we;
    logic                 cfg_phase;
    logic [PAR_NUM_W-1:0] cfg_idx;
    logic [ADDR_W-1:0]    cfg_addr;
    logic [SIZE_W-1:0]    cfg_size;
    logic [PE_NUM-1:0]    pe_req;
    logic [PE_NUM-1:0]    pe_done;
    logic                 grant_valid;
    logic [PE_NUM-1:0]    grant_pe;
    logic [PAR_NUM_W-1:0] grant_par;
    logic [ADDR_W-1:0]    grant_addr;
    logic [SIZE_W-1:0]    grant_size;
    logic [PE_NUM-1:0]    pe_busy;
    logic                 phase_done;
    logic                 err;

    modport master (
        output control, cfg_we, cfg_phase, cfg_idx, cfg_addr, cfg_size, pe_req, pe_done,
        input  grant_valid, grant_pe, grant_par, grant_addr, grant_size, pe_busy, phase_done, err
    );
    modport slave (
        input  control, cfg_we, cfg_phase, cfg_idx, cfg_addr, cfg_size, pe_req, pe_done,
        output grant_valid, grant_pe, grant_par, grant_addr, grant_size, pe_busy, phase_done, err
    );
endinterface

// File: rtl/par_dispatcher_rr_arbiter.sv
// par_dispatcher_rr_arbiter: combinational round-robin pick.
// eligible: request vector; ptr: highest-priority index; gnt: one-hot pick; idx: encoded pick.
// N must equal 2**W so the scan wraps naturally in W bits.
module par_dispatcher_rr_arbiter #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    // Scan from farthest to nearest so the last hit is the first eligible at or after ptr.
    always_comb begin
        idx = '0;
        gnt = '0;
        for (int k = N - 1; k >= 0; k--)
            if (eligible[ptr + W'(k)]) idx = ptr + W'(k);
        gnt[idx] = |eligible;
    end
endmodule

// File: rtl/par_dispatcher.sv
// par_dispatcher: dynamic scatter/gather partition dispatcher for the SpMV PE array.
// clk, rst: clock and synchronous active-high reset.
// bus (slave): control phase, table config writes, PE req/done in; grants, pe_busy,
// phase_done and sticky err out.
module par_dispatcher
    import par_dispatcher_pkg::*;
#(
    parameter int PE_NUM    = 16,
    parameter int PE_NUM_W  = 4,
    parameter int PAR_NUM   = 32,
    parameter int PAR_NUM_W = 5
) (
    input logic clk,
    input logic rst,
    par_dispatcher_if.slave bus
);
    localparam logic [PAR_NUM_W:0] PAR_CNT = (PAR_NUM_W + 1)'(PAR_NUM);

    state_e               state, state_nxt;
    logic                 cur_phase;
    logic [PAR_NUM_W:0]   next_par, retire_cnt;
    logic [PE_NUM_W-1:0]  rr_ptr, pick_idx;
    logic [PE_NUM-1:0]    elig, pick;
    logic                 ctl_run, ctl_phase, enter, abort, fire;
    entry_t               tbl [2*PAR_NUM];

    assign ctl_run   = bus.control == PH_SCATTER || bus.control == PH_GATHER;
    assign ctl_phase = bus.control == PH_GATHER;
    assign elig      = bus.pe_req & ~bus.pe_busy;

    par_dispatcher_rr_arbiter #(.N(PE_NUM), .W(PE_NUM_W)) u_arb (
        .eligible(elig),
        .ptr(rr_ptr),
        .gnt(pick),
        .idx(pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = ctl_run ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = !ctl_run ? S_IDLE : next_par == PAR_CNT ? S_DRAIN : S_RUN;
            S_DRAIN: state_nxt = !ctl_run ? S_IDLE :
                                 (retire_cnt == PAR_CNT && bus.pe_busy == '0) ? S_DONE : S_DRAIN;
            S_DONE:  state_nxt = !ctl_run ? S_IDLE : ctl_phase != cur_phase ? S_RUN : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grants are gated by ctl_run so an abort cycle never issues one.
    always_comb begin
        enter          = ctl_run && (state == S_IDLE || (state == S_DONE && ctl_phase != cur_phase));
        abort          = !ctl_run && (state == S_RUN || state == S_DRAIN);
        fire           = state == S_RUN && ctl_run && next_par != PAR_CNT && |elig;
        bus.phase_done = state == S_DONE;
    end

    always_ff @(posedge clk) begin
        if (bus.cfg_we && state == S_IDLE)
            tbl[{bus.cfg_phase, bus.cfg_idx}] <= '{addr: bus.cfg_addr, size: bus.cfg_size};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_phase       <= 1'b0;
            next_par        <= '0;
            retire_cnt      <= '0;
            rr_ptr          <= '0;
            bus.pe_busy     <= '0;
            bus.err         <= 1'b0;
            bus.grant_valid <= 1'b0;
            bus.grant_pe    <= '0;
            bus.grant_par   <= '0;
            bus.grant_addr  <= '0;
            bus.grant_size  <= '0;
        end else begin
            bus.grant_valid <= fire;
            bus.grant_pe    <= fire ? pick : '0;
            bus.err         <= bus.err | |(bus.pe_done & ~bus.pe_busy);
            bus.pe_busy     <= abort ? '0 : (bus.pe_busy & ~bus.pe_done) | (fire ? pick : '0);
            if (enter) begin
                cur_phase  <= ctl_phase;
                next_par   <= '0;
                retire_cnt <= '0;
            end else begin
                next_par   <= next_par + (PAR_NUM_W + 1)'(fire);
                retire_cnt <= retire_cnt + (PAR_NUM_W + 1)'($countones(bus.pe_done & bus.pe_busy));
            end
            if (fire) begin
                rr_ptr                         <= pick_idx + PE_NUM_W'(1);
                bus.grant_par                  <= next_par[PAR_NUM_W-1:0];
                {bus.grant_addr, bus.grant_size} <= tbl[{cur_phase, next_par[PAR_NUM_W-1:0]}];
            end
        end
    end
endmodule

// File: tb/tb_par_dispatcher.sv
// tb_par_dispatcher: directed self-checking bench for par_dispatcher (PE_NUM=4, PAR_NUM=4).
module tb_par_dispatcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    par_dispatcher_if #(.PE_NUM(4), .PAR_NUM_W(2)) bus ();

    par_dispatcher #(.PE_NUM(4), .PE_NUM_W(2), .PAR_NUM(4), .PAR_NUM_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] pe, input logic [1:0] par,
                             input logic [31:0] addr, input logic [31:0] size);
        chk({tag, ".valid"}, 64'(bus.grant_valid), 64'(1));
        chk({tag, ".pe"}, 64'(bus.grant_pe), 64'(pe));
        chk({tag, ".par"}, 64'(bus.grant_par), 64'(par));
        chk({tag, ".addr"}, 64'(bus.grant_addr), 64'(addr));
        chk({tag, ".size"}, 64'(bus.grant_size), 64'(size));
    endtask

    initial begin
        bus.control = 2'd0;
        bus.cfg_we = 1'b0;
        bus.cfg_phase = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_addr = '0;
        bus.cfg_size = '0;
        bus.pe_req = '0;
        bus.pe_done = '0;
        tick();
        tick();
        chk("rst.valid", 64'(bus.grant_valid), 64'(0));
        chk("rst.pe", 64'(bus.grant_pe), 64'(0));
        chk("rst.busy", 64'(bus.pe_busy), 64'(0));
        chk("rst.done", 64'(bus.phase_done), 64'(0));
        chk("rst.err", 64'(bus.err), 64'(0));
        rst = 1'b0;

        // Table load in IDLE: scatter addr 0x100*k size k+1, gather addr 0x1000+0x10*k size 0x20+k
        for (int k = 0; k < 4; k++) begin
            bus.cfg_we = 1'b1;
            bus.cfg_phase = 1'b0;
            bus.cfg_idx = 2'(k);
            bus.cfg_addr = 32'(32'h100 * k);
            bus.cfg_size = 32'(k + 1);
            tick();
            bus.cfg_phase = 1'b1;
            bus.cfg_addr = 32'(32'h1000 + 32'h10 * k);
            bus.cfg_size = 32'(32'h20 + k);
            tick();
        end
        bus.cfg_we = 1'b0;

        // Basic scatter dispatch, all PEs requesting
        bus.pe_req = 4'hF;
        bus.control = 2'd1;
        tick();
        chk("enter.valid", 64'(bus.grant_valid), 64'(0));
        bus.cfg_we = 1'b1;
        bus.cfg_phase = 1'b1;
        bus.cfg_idx = 2'd0;
        bus.cfg_addr = 32'hDEAD;
        bus.cfg_size = 32'hDEAD;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.cfg_we = 1'b0;
            chk_grant($sformatf("basic%0d", k), 4'(1 << k), 2'(k), 32'(32'h100 * k), 32'(k + 1));
            chk($sformatf("basic%0d.busy", k), 64'(bus.pe_busy), 64'((2 << k) - 1));
        end
        tick();
        chk("drain.valid", 64'(bus.grant_valid), 64'(0));
        bus.pe_done = 4'b0111;
        tick();
        chk("ret3.busy", 64'(bus.pe_busy), 64'(4'b1000));
        chk("ret3.done", 64'(bus.phase_done), 64'(0));
        bus.pe_done = 4'b0001;
        tick();
        chk("spur.err", 64'(bus.err), 64'(1));
        chk("spur.busy", 64'(bus.pe_busy), 64'(4'b1000));
        chk("spur.done", 64'(bus.phase_done), 64'(0));
        bus.pe_done = 4'b0000;
        tick();
        chk("spur2.done", 64'(bus.phase_done), 64'(0));
        bus.pe_done = 4'b1000;
        tick();
        chk("ret4.busy", 64'(bus.pe_busy), 64'(0));
        chk("ret4.done", 64'(bus.phase_done), 64'(0));
        chk("ret4.valid", 64'(bus.grant_valid), 64'(0));
        bus.pe_done = 4'b0000;
        tick();
        chk("sc.done", 64'(bus.phase_done), 64'(1));
        tick();
        chk("sc.hold", 64'(bus.phase_done), 64'(1));
        chk("sc.err", 64'(bus.err), 64'(1));

        // Direct switch to gather; lockout of the 0xDEAD write
        bus.control = 2'd2;
        bus.pe_req = 4'b0100;
        tick();
        chk("ga.enter.done", 64'(bus.phase_done), 64'(0));
        chk("ga.enter.valid", 64'(bus.grant_valid), 64'(0));
        tick();
        chk_grant("ga0", 4'b0100, 2'd0, 32'h1000, 32'h20);
        // Done and request from PE2 in the same cycle
        bus.pe_done = 4'b0100;
        tick();
        bus.pe_done = 4'b0000;
        chk("dr.busy", 64'(bus.pe_busy), 64'(0));
        chk("dr.valid", 64'(bus.grant_valid), 64'(0));
        tick();
        chk_grant("ga1", 4'b0100, 2'd1, 32'h1010, 32'h21);

        // Abort after 2 of 4 grants
        bus.control = 2'd0;
        bus.pe_req = 4'hF;
        tick();
        chk("abort.valid", 64'(bus.grant_valid), 64'(0));
        chk("abort.busy", 64'(bus.pe_busy), 64'(0));
        tick();
        chk("abort2.valid", 64'(bus.grant_valid), 64'(0));
        chk("abort2.done", 64'(bus.phase_done), 64'(0));

        // Restart scatter with PE1/PE3 only; rr_ptr is 3 from the last grant
        bus.control = 2'd1;
        bus.pe_req = 4'b1010;
        tick();
        chk("rr.enter.valid", 64'(bus.grant_valid), 64'(0));
        tick();
        chk_grant("rr0", 4'b1000, 2'd0, 32'h0, 32'h1);
        tick();
        chk_grant("rr1", 4'b0010, 2'd1, 32'h100, 32'h2);
        bus.pe_done = 4'b1000;
        tick();
        chk("rr.gap.valid", 64'(bus.grant_valid), 64'(0));
        chk("rr.gap.busy", 64'(bus.pe_busy), 64'(4'b0010));
        bus.pe_done = 4'b0010;
        tick();
        chk_grant("rr2", 4'b1000, 2'd2, 32'h200, 32'h3);
        bus.pe_done = 4'b0000;
        tick();
        chk_grant("rr3", 4'b0010, 2'd3, 32'h300, 32'h4);
        bus.pe_done = 4'b1010;
        tick();
        bus.pe_done = 4'b0000;
        chk("rr.ret.valid", 64'(bus.grant_valid), 64'(0));
        chk("rr.ret.busy", 64'(bus.pe_busy), 64'(0));
        chk("rr.ret.done", 64'(bus.phase_done), 64'(0));
        tick();
        chk("rr.done", 64'(bus.phase_done), 64'(1));
        chk("rr.err", 64'(bus.err), 64'(1));

        bus.control = 2'd0;
        tick();
        chk("idle.done", 64'(bus.phase_done), 64'(0));
        rst = 1'b1;
        tick();
        chk("rst2.err", 64'(bus.err), 64'(0));
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/par_dispatcher.md
Name: par_dispatcher

Overview:
- Global dynamic partition dispatcher for the SpMV engine. It hands out scatter/gather partitions from a shared pool to the PEs on demand, replacing static per-PE partition assignment.
- Sits between the top-level IDLE/SCATTER/GATHER phase controller and the PE array. It holds a partition table (base DRAM address and work size per partition, per phase) and round-robin arbitrates PE requests.
- It reports phase completion when every partition of the current phase has been granted and retired.

Parameters:
- PE_NUM, 16, number of PEs (requesters)
- PE_NUM_W, 4, log2(PE_NUM)
- PAR_NUM, 32, partitions per phase
- PAR_NUM_W, 5, log2(PAR_NUM)
- ADDR_W, 32, DRAM read-address width
- SIZE_W, 32, work-size width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- control  in  2  top-level phase: 0 IDLE, 1 SCATTER, 2 GATHER (3 treated as IDLE)
- cfg_we  in  1  partition-table write strobe
- cfg_phase  in  1  table select: 0 scatter, 1 gather
- cfg_idx  in  PAR_NUM_W  partition index
- cfg_addr  in  ADDR_W  partition base read address
- cfg_size  in  SIZE_W  partition work size
- pe_req  in  PE_NUM  per-PE request for a new partition (level)
- pe_done  in  PE_NUM  per-PE one-cycle pulse: current partition complete
- grant_valid  out  1  one-cycle grant pulse
- grant_pe  out  PE_NUM  one-hot granted PE
- grant_par  out  PAR_NUM_W  granted partition index
- grant_addr  out  ADDR_W  granted base address
- grant_size  out  SIZE_W  granted work size
- pe_busy  out  PE_NUM  PE currently owns a partition
- phase_done  out  1  all partitions of the current phase retired (level)
- err  out  1  sticky: pe_done received from a non-busy PE

Behaviour:
- Reset: all outputs 0; FSM in S_IDLE; next_par=0; retire_cnt=0; rr_ptr=0. Table contents are not reset.
- FSM states:
  - S_IDLE → S_RUN when control∈{1,2}; entry latches cur_phase=control-1 and clears next_par, retire_cnt and phase_done.
  - S_RUN → S_DRAIN when next_par reaches PAR_NUM.
  - S_DRAIN → S_DONE when retire_cnt==PAR_NUM and pe_busy==0.
  - S_DONE: phase_done=1, held until control changes. A change to IDLE → S_IDLE. A change directly to the other phase → S_RUN with a fresh phase entry.
- Table writes are accepted only in S_IDLE; they are ignored in other states. Table storage is 2×PAR_NUM entries of {addr,size}, indexed by {cfg_phase,cfg_idx}.
- Eligibility = pe_req & ~pe_busy, using the registered pe_busy.
- Grant, in S_RUN only, when eligibility≠0:
  - Select the first eligible PE scanning from rr_ptr upward modulo PE_NUM.
  - Next cycle (1-cycle latency): grant_valid=1, grant_pe one-hot, grant_par=next_par, and grant_addr/grant_size from table[cur_phase][next_par].
  - At the same edge: pe_busy[i] set, next_par incremented, rr_ptr=(i+1) mod PE_NUM.
- At most one grant per cycle. No grant in S_DRAIN, S_DONE or S_IDLE.
- pe_done[i] with pe_busy[i]=1: clear pe_busy[i] and increment retire_cnt. Multiple simultaneous done pulses are all counted (popcount).
- pe_done[i] with pe_busy[i]=0: ignored for counting and sets err; err is cleared only by rst.
- A done pulse and a new request from the same PE in the same cycle: busy clears at the edge, so the PE becomes eligible the following cycle. Grant and done to the same PE in one cycle are impossible, because a grant requires ~busy.
- A zero-size partition is granted normally; the PE retires it by pulsing pe_done.
- Abort: control→IDLE while in S_RUN or S_DRAIN → S_IDLE next cycle. pe_busy cleared, no further grants; any pending grant_valid is suppressed.
- Counters: next_par and retire_cnt are PAR_NUM_W+1 bits wide so they can hold PAR_NUM without wrapping.

Decomposition:
- Shared package: phase encodings (IDLE/SCATTER/GATHER), FSM state enum, table entry struct {addr,size}.
- One natural sub-module: rr_arbiter (PE_NUM-wide round-robin priority pick). Inputs are eligibility vector and rr_ptr; outputs are one-hot grant and encoded index; purely combinational.

Test Plan:
- Basic dispatch, PE_NUM=4, PAR_NUM=4, scatter table addr=0x100·k, size=k+1: control=1, all req=1 → grants on 4 consecutive cycles to PE0..3, par 0..3, addrs 0x000/0x100/0x200/0x300. Pulse all done → phase_done=1 one cycle after the last done.
- Round-robin fairness: only PE1 and PE3 request continuously, each done pulsed 2 cycles after its grant → grants alternate PE1, PE3, PE1, PE3; PE0 and PE2 are never granted.
- Simultaneous done+req: PE2 pulses done and holds req in cycle t → PE2 is granted no earlier than the grant_valid at cycle t+2. pe_busy[2] is 0 at t+1.
- Spurious done: pe_done[0] while pe_busy[0]=0 → err=1 sticky, retire_cnt unchanged, phase_done still requires all PAR_NUM retirements.
- Abort: control 1→0 after 2 of 4 grants → no further grant_valid, pe_busy=0 next cycle. Re-entering control=1 restarts at par 0.
- Phase switch and config lockout: cfg_we during S_RUN writing gather idx0 addr=0xDEAD is ignored. After scatter done, control→2 → grant_addr comes from the gather table values loaded in S_IDLE.
